// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL lock reset sequencer.
// Contents:
//   rst_state_t    - sequencer FSM states
//   DEF_*          - default parameter values for pll_lock_reset_gen
//   LOSS_CNT_W     - width of the saturating lock-loss counter
//   max_int()      - elaboration-time helper used to size the shared counter
package pll_rst_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } rst_state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 16;
    localparam int DEF_RESET_HOLD_CYCLES  = 8;
    localparam int DEF_TIMEOUT_CYCLES     = 65536;

    localparam int LOSS_CNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer for a single asynchronous status bit.
// All stages clear to 0 on the asynchronous reset.
// Ports:
//   clk_i - destination clock
//   rst_i - asynchronous active-high reset
//   d_i   - asynchronous input bit
//   q_o   - synchronized output (STAGES clock edges of latency)
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_gen.sv
// Reset sequencer downstream of the PLL. Releases the system reset only after
// the synchronized LOCKED signal has been stable for LOCK_STABLE_CYCLES and a
// further RESET_HOLD_CYCLES hold interval has elapsed. Any lock loss re-enters
// the wait state and re-asserts reset.
// Ports:
//   clk          - PLL output clock, the only clock
//   rst          - asynchronous active-high reset (power-on / button)
//   locked       - PLL LOCKED, asynchronous to clk
//   rst_out      - active-high system reset (async assert, sync deassert)
//   rst_n_out    - registered complement of rst_out
//   ready        - high only in RUN
//   lock_timeout - sticky: no lock within TIMEOUT_CYCLES while waiting
//   loss_count   - saturating count of RUN -> WAIT_LOCK transitions
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET     | held by rst; all outputs at reset values
// WAIT_LOCK | waiting for locked_s; tcnt counts towards the timeout
// STABLE    | locked_s high; cnt counts qualifying cycles
// HOLD      | lock qualified; rst_out still asserted for the hold interval
// RUN       | rst_out released, ready high
module pll_lock_reset_gen
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    output logic                  rst_out,
    output logic                  rst_n_out,
    output logic                  ready,
    output logic                  lock_timeout,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int CNT_W  = $clog2(max_int(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES) + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W:0]    LSC_C  = (CNT_W+1)'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  RHC_C  = CNT_W'(RESET_HOLD_CYCLES);
    localparam logic [TCNT_W-1:0] TMO_C  = TCNT_W'(TIMEOUT_CYCLES);

    rst_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W:0]          cnt_inc;
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d, tcnt_inc;
    logic                    timeout_q, timeout_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
    logic                    rst_out_q, rst_n_q, ready_q;
    logic                    armed_q;
    logic                    locked_gated;
    logic                    locked_s;

    // Lock is not allowed into the synchronizer until the FSM has left RESET,
    // so the qualification latency is always measured from WAIT_LOCK. This is
    // why a release with lock already present takes one extra edge.
    assign locked_gated = locked & armed_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (locked_gated),
        .q_o   (locked_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
            loss_q    <= '0;
            rst_out_q <= 1'b1;
            rst_n_q   <= 1'b0;
            ready_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
            loss_q    <= loss_d;
            rst_out_q <= (state_d != RUN);
            rst_n_q   <= (state_d == RUN);
            ready_q   <= (state_d == RUN);
            armed_q   <= (state_d != RESET);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        loss_d    = loss_q;
        cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
        tcnt_inc  = tcnt_q + TCNT_W'(1);

        case (state_q)
            RESET: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                tcnt_d  = '0;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = CNT_W'(1);
                end else if (tcnt_q != TMO_C) begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == TMO_C) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            STABLE: begin
                // The WAIT_LOCK cycle that saw locked_s is stable cycle 1,
                // so the exit test looks at the incremented count.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end else if (cnt_inc >= LSC_C) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end else if (cnt_q >= RHC_C) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    tcnt_d  = '0;
                    if (loss_q != '1) begin
                        loss_d = loss_q + LOSS_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = RESET;
            end
        endcase
    end

    assign rst_out      = rst_out_q;
    assign rst_n_out    = rst_n_q;
    assign ready        = ready_q;
    assign lock_timeout = timeout_q;
    assign loss_count   = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// Scoreboard bench for pll_lock_reset_gen. Stimulus pushes the expected output
// vector for a given cycle; the monitor pops and compares on falling edges.
module tb_pll_lock_reset_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       rst_out, rst_n_out, ready, lock_timeout;
    logic [7:0] loss_count;

    always #5 clk = ~clk;

    pll_lock_reset_gen #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (16),
        .RESET_HOLD_CYCLES  (8),
        .TIMEOUT_CYCLES     (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked),
        .rst_out      (rst_out),
        .rst_n_out    (rst_n_out),
        .ready        (ready),
        .lock_timeout (lock_timeout),
        .loss_count   (loss_count)
    );

    // cyc == N after rising edge N
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       name;
        logic [11:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;
    bit   flushed  = 1'b0;

    function automatic logic [11:0] pack(input logic ro, input logic rn, input logic rd,
                                         input logic to, input logic [7:0] lc);
        return {ro, rn, rd, to, lc};
    endfunction

    // {rst_out, rst_n_out, ready, lock_timeout, loss_count}; rst_n_out is always ~rst_out
    task automatic expect_at(input int at, input string nm, input bit ro, input bit rd,
                             input bit to, input int lc);
        logic [7:0] l8;
        exp_t e;
        l8 = lc[7:0];
        e.at   = at;
        e.name = nm;
        e.vec  = pack(ro, ~ro, rd, to, l8);
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget, input int lc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (ready === 1'b1) seen = 1'b1;
        end
        if (!seen) expect_at(cyc, "relock_ready", 1'b0, 1'b1, 1'b0, lc);
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            act = pack(rst_out, rst_n_out, ready, lock_timeout, loss_count);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.at < cyc) begin
                    n_fail++;
                    $display("FAIL %s: due at cycle %0d, reached only at cycle %0d", e.name, e.at, cyc);
                end else if (act !== e.vec) begin
                    n_fail++;
                    $display("FAIL %s @cycle %0d: got rst_out=%b rst_n_out=%b ready=%b lock_timeout=%b loss_count=%0d, required rst_out=%b rst_n_out=%b ready=%b lock_timeout=%b loss_count=%0d",
                             e.name, cyc, act[11], act[10], act[9], act[8], act[7:0],
                             e.vec[11], e.vec[10], e.vec[9], e.vec[8], e.vec[7:0]);
                end
            end
            if (done && !flushed) begin
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.at, cyc);
                end
                flushed = 1'b1;
            end
        end
    end

    // Stimulus
    initial begin
        int r, c, g;
        rst    = 1'b1;
        locked = 1'b0;

        tick(3);
        expect_at(cyc, "reset_state", 1, 0, 0, 0);

        // Clean lock: edge 1 samples locked high, rst_out falls at edge 26
        tick(1); rst = 1'b0; r = cyc;
        expect_at(r + 1, "wait_lock", 1, 0, 0, 0);
        tick(2); locked = 1'b1; c = cyc;
        expect_at(c + 25, "clean_pre", 1, 0, 0, 0);
        expect_at(c + 26, "clean_run", 0, 1, 0, 0);
        tick(30);

        // Async reset from RUN is visible before the next edge
        rst = 1'b1;
        expect_at(cyc, "async_rst_run", 1, 0, 0, 0);
        tick(2); rst = 1'b0; r = cyc;

        // Abort during HOLD, then release with lock already present: edge 27
        tick(22); rst = 1'b1;
        expect_at(cyc, "async_rst_hold", 1, 0, 0, 0);
        tick(2); rst = 1'b0; r = cyc;
        expect_at(r + 26, "abort_pre", 1, 0, 0, 0);
        expect_at(r + 27, "abort_run", 0, 1, 0, 0);
        tick(30);

        // One-cycle glitch during STABLE at cnt=10 restarts the sequence
        rst = 1'b1; locked = 1'b0;
        tick(2); rst = 1'b0;
        tick(3); locked = 1'b1; g = cyc;
        expect_at(g + 26, "glitch_norun", 1, 0, 0, 0);
        tick(12); locked = 1'b0;
        tick(1);  locked = 1'b1;
        expect_at(g + 38, "glitch_pre", 1, 0, 0, 0);
        expect_at(g + 39, "glitch_run", 0, 1, 0, 0);
        tick(45);

        // Lock loss in RUN: sampled low at edge c+1, reset re-asserted two edges later
        locked = 1'b0; c = cyc;
        expect_at(c + 2, "loss_pre", 0, 1, 0, 0);
        expect_at(c + 3, "loss_rst", 1, 0, 0, 1);
        tick(5); locked = 1'b1; c = cyc;
        expect_at(c + 25, "relock_pre", 1, 0, 0, 1);
        expect_at(c + 26, "relock_run", 0, 1, 0, 1);
        tick(30);

        // Saturation of loss_count
        for (int k = 2; k <= 260; k++) begin
            locked = 1'b0; c = cyc;
            expect_at(c + 3, "sat_loss", 1, 0, 0, (k > 255) ? 255 : k);
            tick(5); locked = 1'b1;
            wait_ready(40, (k > 255) ? 255 : k);
            tick(1);
        end

        rst = 1'b1; locked = 1'b0;
        expect_at(cyc, "sat_clear", 1, 0, 0, 0);

        // Timeout after 100 WAIT_LOCK edges, sticky through a later lock
        tick(2); rst = 1'b0; r = cyc;
        expect_at(r + 100, "tmo_pre", 1, 0, 0, 0);
        expect_at(r + 101, "tmo_set", 1, 0, 1, 0);
        tick(105); locked = 1'b1; c = cyc;
        expect_at(c + 25, "tmo_lock_pre", 1, 0, 1, 0);
        expect_at(c + 26, "tmo_sticky_run", 0, 1, 1, 0);
        tick(30);
        rst = 1'b1;
        expect_at(cyc, "tmo_clear", 1, 0, 0, 0);

        tick(40);
        done = 1'b1;
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
